fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch sequencer directly upstream of the instruction register.
- Owns the PC and a fetch address latch, and runs a memory read handshake.
- Delivers the fetched 32-bit word, with a one-cycle IRin strobe, to the IR load path.
- Accepts branch/jump PC redirects from the control unit and detects memory timeouts.

Parameters:
- ADDR_W, 9: memory word-address width; mem_addr = fetch address [ADDR_W-1:0].
- PC_RESET, 0: PC value after reset.
- MAX_WAIT, 15: WAIT cycles without mem_ack before the fetch aborts; legal range 1..255.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  asynchronous, active-low reset.
- fetch_start  in  1  request one instruction fetch; sampled only in IDLE.
- pc_load  in  1  redirect PC to pc_target.
- pc_target  in  32  branch/jump target address.
- mem_rd  out  1  memory read request.
- mem_addr  out  ADDR_W  word address to memory.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  memory read data.
- IR_word  out  32  fetched instruction, drives the IR load path.
- IRin  out  1  one-cycle IR load strobe.
- PC  out  32  current program counter.
- fetch_busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (Clear=0, asynchronous, any state): state=IDLE, PC=PC_RESET, fetch address latch=PC_RESET, MDR=0, IR_word=0, pending redirect cleared, wait counter=0. All strobes (mem_rd, IRin, fetch_err, fetch_busy) drop to 0 immediately, without waiting for a clock edge.
- States: IDLE, ADDR, WAIT, LOAD; registered, Moore-style outputs.
- IDLE:
  - fetch_start=1 -> ADDR.
  - pc_load=1 -> PC <= pc_target.
  - Both in the same cycle: the fetch uses the new PC.
- ADDR (1 cycle): latch <= PC, PC <= PC+1 (modulo 2^32), wait counter <= 0; -> WAIT.
- WAIT:
  - mem_rd=1; mem_addr = latch[ADDR_W-1:0], held stable for the whole state.
  - mem_ack=1: MDR <= mem_rdata; -> LOAD.
  - Otherwise the counter increments. If the counter reaches MAX_WAIT-1 with no ack: fetch_err=1 for the next cycle, PC <= latch (restore PC for refetch), -> IDLE.
  - mem_ack outside WAIT is ignored.
- LOAD (1 cycle):
  - IRin=1 and IR_word=MDR.
  - -> IDLE.
  - IR_word holds its value until the next LOAD.
- Latency: fetch_start sampled at edge k, ack in the first WAIT cycle -> IRin high during cycle k+3. Each extra wait cycle adds 1.
- fetch_busy = (state != IDLE).
- pc_load while busy is latched into a pending register (last one wins). On the transition into IDLE (LOAD or timeout), the pending target overwrites PC, taking precedence over both the incremented PC and the timeout restore.
- The in-flight fetch always completes from its original address; a redirect never aborts it.
- A fetch_start arriving while busy is dropped; the control unit re-asserts it.
- Back-to-back fetches: fetch_start may be asserted in the first IDLE cycle after LOAD. Minimum issue interval is 4 cycles.
- Address wrap: PC=2^ADDR_W-1 fetches that address. Next PC = 2^ADDR_W, so mem_addr wraps to 0 while PC stays a full 32-bit value.

Decomposition:
- Shared package:
  - fetch state encoding (2-bit enum: IDLE, ADDR, WAIT, LOAD);
  - INSTR_W=32;
  - default ADDR_W and MAX_WAIT constants, shared with the memory model and control unit.
- One sub-module, fetch_wait_timer: 8-bit counter with clear/enable and a terminal-count output compared to MAX_WAIT-1, on the same asynchronous reset.
- The FSM, PC, address latch and MDR stay in fetch_unit.

Test Plan:
- Reset, then fetch_start; memory at address 0 returns 0x1A100000 with ack in the first WAIT cycle -> mem_addr=0, IRin high exactly 1 cycle at k+3, IR_word=0x1A100000, PC=1.
- Ack delayed 4 cycles, PC=3 -> mem_rd held 5 cycles with mem_addr=3 stable, single IRin, PC=4.
- Never ack, MAX_WAIT=15, PC=5 -> fetch_err pulses once after 15 WAIT cycles, no IRin, PC=5, fetch_busy=0. A following fetch re-reads address 5.
- pc_load with pc_target=0x20 during WAIT of a fetch at 7 -> instruction from 7 loaded, then PC=0x20. The next fetch drives mem_addr=0x20, and PC=0x21 afterwards.
- pc_load (0x40) and fetch_start in the same IDLE cycle -> mem_addr=0x40, PC=0x41 after ADDR.
- Clear driven low mid-WAIT -> mem_rd falls combinationally, PC=0. Separately, PC=0x1FF with ADDR_W=9 -> fetch from 0x1FF, PC=0x200, next mem_addr=0x000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch state encoding and default sizes shared by the fetch path,
// the memory model and the control unit.
package fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_MAX_WAIT = 15;
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, LOAD} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory read handshake between the fetch unit and memory.
interface fetch_unit_if import fetch_unit_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
  logic rd;
  logic [ADDR_W-1:0] addr;
  logic ack;
  logic [INSTR_W-1:0] rdata;
  modport master (output rd, addr, input ack, rdata);
  modport slave (input rd, addr, output ack, rdata);
endinterface

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: counts WAIT cycles and flags the last cycle before a fetch timeout.
module fetch_wait_timer import fetch_unit_pkg::*; #(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = cnt_q == 8'(MAX_WAIT - 1);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer owning the PC, fetch address latch and MDR;
// runs the memory read handshake and strobes the fetched word into the IR path.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [INSTR_W-1:0] PC_RESET = '0,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       mem,
  input  logic               fetch_start_i,
  input  logic               pc_load_i,
  input  logic [INSTR_W-1:0] pc_target_i,
  output logic [INSTR_W-1:0] ir_word_o,
  output logic               ir_in_o,
  output logic [INSTR_W-1:0] pc_o,
  output logic               fetch_busy_o,
  output logic               fetch_err_o
);
  fetch_state_e state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d, lat_q, lat_d, mdr_q, mdr_d, ir_q, ir_d, pend_t_q, pend_t_d;
  logic pend_v_q, pend_v_d, err_q, timeout, tc;

  fetch_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q == ADDR), .en_i(state_q == WAIT), .tc_o(tc)
  );

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    lat_d = lat_q;
    mdr_d = mdr_q;
    ir_d = ir_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = fetch_start_i ? ADDR : IDLE;
        pc_d = pc_load_i ? pc_target_i : pc_q;
      end
      ADDR: begin
        lat_d = pc_q;
        pc_d = pc_q + 32'd1;
        state_d = WAIT;
      end
      WAIT:
        if (mem.ack) begin
          mdr_d = mem.rdata;
          state_d = LOAD;
        end else if (tc) begin
          timeout = 1'b1;
          pc_d = lat_q;
          state_d = IDLE;
        end
      LOAD: begin
        ir_d = mdr_q;
        state_d = IDLE;
      end
    endcase
    if (state_q != IDLE && pc_load_i) begin
      pend_v_d = 1'b1;
      pend_t_d = pc_target_i;
    end
    // a redirect seen while busy wins over both PC+1 and the timeout restore
    if (state_q != IDLE && state_d == IDLE) begin
      pc_d = pend_v_d ? pend_t_d : pc_d;
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= PC_RESET;
      lat_q <= PC_RESET;
      mdr_q <= '0;
      ir_q <= '0;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      lat_q <= lat_d;
      mdr_q <= mdr_d;
      ir_q <= ir_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      err_q <= timeout;
    end

  assign mem.rd = state_q == WAIT;
  assign mem.addr = lat_q[ADDR_W-1:0];
  assign ir_in_o = state_q == LOAD;
  assign ir_word_o = ir_in_o ? mdr_q : ir_q;
  assign pc_o = pc_q;
  assign fetch_busy_o = state_q != IDLE;
  assign fetch_err_o = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit with a transaction-level
// model of PC, IR and handshake timing.
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam int MW = 15;
  logic clk, rst_n, fetch_start, pc_load, ir_in, busy, err;
  logic [31:0] pc_target, ir_word, pc;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc, m_ir;

  fetch_unit_if #(.ADDR_W(9)) mem ();

  fetch_unit #(.ADDR_W(9), .PC_RESET(32'd0), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem), .fetch_start_i(fetch_start), .pc_load_i(pc_load),
    .pc_target_i(pc_target), .ir_word_o(ir_word), .ir_in_o(ir_in), .pc_o(pc),
    .fetch_busy_o(busy), .fetch_err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 plain, 1 pc_load together with fetch_start, 2 pc_load in first WAIT cycle
  // dly: WAIT cycles before ack; >= MW means memory never acks
  task automatic run_fetch(input int dly, input int mode, input logic [31:0] tgt, input logic [31:0] data,
                           output int rd_n, output logic [8:0] addr, output bit stable, output int irin_n,
                           output int irin_at, output int err_n, output int done_at, output logic [31:0] ir);
    int w = 0;
    rd_n = 0; irin_n = 0; irin_at = -1; err_n = 0; done_at = -1; stable = 1; addr = '0; ir = '0;
    fetch_start = 1'b1;
    pc_load = mode == 1;
    pc_target = tgt;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      fetch_start = 1'b0;
      pc_load = 1'b0;
      if (mem.rd) begin
        if (rd_n == 0) addr = mem.addr;
        else if (mem.addr !== addr) stable = 0;
        rd_n++;
      end
      if (ir_in) begin
        irin_n++;
        if (irin_at < 0) irin_at = i;
      end
      if (err) err_n++;
      if (!busy) begin
        done_at = i;
        ir = ir_word;
        break;
      end
      if (mem.rd) begin
        mem.ack = w == dly;
        mem.rdata = mem.ack ? data : $urandom;
        w++;
        pc_load = mode == 2 && w == 1;
        pc_target = $urandom;
        if (pc_load) pc_target = tgt;
      end else begin
        mem.ack = 1'($urandom);
        mem.rdata = $urandom;
      end
      fetch_start = 1'($urandom);
    end
    mem.ack = 1'b0;
    fetch_start = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_load = 1'b1;
    pc_target = v;
    @(negedge clk);
    pc_load = 1'b0;
    m_pc = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_start = 0; pc_load = 0; pc_target = 0; mem.ack = 0; mem.rdata = 0;
    #3;
    n_cmp++; if (pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc got %h want 0", pc); end
    n_cmp++; if ({mem.rd, ir_in, busy, err} !== 4'b0) begin n_bad++; $display("FAIL reset_strobes got %b want 0000", {mem.rd, ir_in, busy, err}); end
    n_cmp++; if (ir_word !== 32'd0) begin n_bad++; $display("FAIL reset_ir got %h want 0", ir_word); end
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0; m_ir = 0;
  endtask

  task automatic test_basic();
    int rd_n, irin_n, irin_at, err_n, done_at; bit st; logic [8:0] a; logic [31:0] ir;
    run_fetch(0, 0, 0, 32'h1A100000, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (a !== 9'd0 || rd_n != 1) begin n_bad++; $display("FAIL basic_rd got addr %h x%0d want 000 x1", a, rd_n); end
    n_cmp++; if (irin_n != 1 || irin_at != 3) begin n_bad++; $display("FAIL basic_irin got %0d at %0d want 1 at 3", irin_n, irin_at); end
    n_cmp++; if (ir !== 32'h1A100000) begin n_bad++; $display("FAIL basic_ir got %h want 1a100000", ir); end
    n_cmp++; if (pc !== 32'd1 || done_at != 4) begin n_bad++; $display("FAIL basic_pc got %h done %0d want 1 done 4", pc, done_at); end
    m_pc = 1; m_ir = 32'h1A100000;
  endtask

  task automatic test_wait();
    int rd_n, irin_n, irin_at, err_n, done_at; bit st; logic [8:0] a; logic [31:0] ir, d;
    d = $urandom;
    set_pc(3);
    run_fetch(4, 0, 0, d, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (rd_n != 5 || a !== 9'd3 || !st) begin n_bad++; $display("FAIL wait_rd got x%0d addr %h stable %0d want x5 003 1", rd_n, a, st); end
    n_cmp++; if (irin_n != 1 || irin_at != 7 || ir !== d) begin n_bad++; $display("FAIL wait_irin got %0d at %0d ir %h want 1 at 7 ir %h", irin_n, irin_at, ir, d); end
    n_cmp++; if (pc !== 32'd4) begin n_bad++; $display("FAIL wait_pc got %h want 4", pc); end
    m_pc = 4; m_ir = d;
  endtask

  task automatic test_timeout();
    int rd_n, irin_n, irin_at, err_n, done_at; bit st; logic [8:0] a; logic [31:0] ir;
    set_pc(5);
    run_fetch(255, 0, 0, 0, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (rd_n != MW || irin_n != 0) begin n_bad++; $display("FAIL timeout_rd got x%0d irin %0d want x%0d irin 0", rd_n, irin_n, MW); end
    n_cmp++; if (err_n != 1 || done_at != MW + 2) begin n_bad++; $display("FAIL timeout_err got %0d done %0d want 1 done %0d", err_n, done_at, MW + 2); end
    n_cmp++; if (pc !== 32'd5 || busy !== 1'b0 || ir !== m_ir) begin n_bad++; $display("FAIL timeout_pc got pc %h busy %b ir %h want 5 0 %h", pc, busy, ir, m_ir); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse got %b want 0", err); end
    run_fetch(0, 0, 0, 32'h5555, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (a !== 9'd5 || pc !== 32'd6) begin n_bad++; $display("FAIL refetch got addr %h pc %h want 005 6", a, pc); end
    m_pc = 6; m_ir = 32'h5555;
  endtask

  task automatic test_redirect();
    int rd_n, irin_n, irin_at, err_n, done_at; bit st; logic [8:0] a; logic [31:0] ir;
    set_pc(7);
    run_fetch(2, 2, 32'h20, 32'hCAFE0007, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (a !== 9'd7 || ir !== 32'hCAFE0007) begin n_bad++; $display("FAIL redir_fetch got addr %h ir %h want 007 cafe0007", a, ir); end
    n_cmp++; if (pc !== 32'h20) begin n_bad++; $display("FAIL redir_pc got %h want 20", pc); end
    run_fetch(0, 0, 0, 1, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (a !== 9'h20 || pc !== 32'h21) begin n_bad++; $display("FAIL redir_next got addr %h pc %h want 020 21", a, pc); end
    run_fetch(0, 1, 32'h40, 2, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (a !== 9'h40 || pc !== 32'h41) begin n_bad++; $display("FAIL load_start got addr %h pc %h want 040 41", a, pc); end
    m_pc = 32'h41; m_ir = 2;
  endtask

  task automatic test_async_reset();
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem.rd !== 1'b1) begin n_bad++; $display("FAIL areset_pre got rd %b want 1", mem.rd); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem.rd !== 1'b0 || busy !== 1'b0 || pc !== 32'd0 || ir_word !== 32'd0) begin
      n_bad++; $display("FAIL areset got rd %b busy %b pc %h ir %h want 0 0 0 0", mem.rd, busy, pc, ir_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0; m_ir = 0;
  endtask

  task automatic test_wrap();
    int rd_n, irin_n, irin_at, err_n, done_at; bit st; logic [8:0] a; logic [31:0] ir;
    set_pc(32'h1FF);
    run_fetch(1, 0, 0, 3, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (a !== 9'h1FF || pc !== 32'h200) begin n_bad++; $display("FAIL wrap_top got addr %h pc %h want 1ff 200", a, pc); end
    run_fetch(0, 0, 0, 4, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
    n_cmp++; if (a !== 9'h000 || pc !== 32'h201) begin n_bad++; $display("FAIL wrap_next got addr %h pc %h want 000 201", a, pc); end
    m_pc = 32'h201; m_ir = 4;
  endtask

  task automatic test_random();
    int dly, mode, rd_n, irin_n, irin_at, err_n, done_at, ok; bit st; logic [8:0] a, ea; logic [31:0] ir, tgt, d;
    for (int t = 0; t < 40; t++) begin
      dly = ($urandom % 5 == 0) ? 255 : int'($urandom_range(0, MW - 1));
      mode = int'($urandom_range(0, 2));
      tgt = $urandom;
      d = $urandom;
      if (mode == 1) m_pc = tgt;
      ea = m_pc[8:0];
      ok = dly < MW ? 1 : 0;
      run_fetch(dly, mode, tgt, d, rd_n, a, st, irin_n, irin_at, err_n, done_at, ir);
      if (ok == 1) begin m_pc = m_pc + 1; m_ir = d; end
      if (mode == 2) m_pc = tgt;
      n_cmp++; if (a !== ea || !st) begin n_bad++; $display("FAIL rnd%0d_addr got %h stable %0d want %h", t, a, st, ea); end
      n_cmp++; if (rd_n != (ok == 1 ? dly + 1 : MW)) begin n_bad++; $display("FAIL rnd%0d_rdlen got %0d dly %0d", t, rd_n, dly); end
      n_cmp++; if (irin_n != ok || err_n != 1 - ok) begin n_bad++; $display("FAIL rnd%0d_strobe got irin %0d err %0d want %0d %0d", t, irin_n, err_n, ok, 1 - ok); end
      n_cmp++; if (done_at != (ok == 1 ? dly + 4 : MW + 2)) begin n_bad++; $display("FAIL rnd%0d_done got %0d dly %0d", t, done_at, dly); end
      n_cmp++; if (pc !== m_pc || ir !== m_ir) begin n_bad++; $display("FAIL rnd%0d_state got pc %h ir %h want %h %h", t, pc, ir, m_pc, m_ir); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_idle got busy %b want 0", t, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_timeout();
    test_redirect();
    test_async_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
